fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: boots from a reset vector, walks the PC, honours branch
// redirects and injects a pseudo-instruction before jumping to the interrupt vector.
module fetch_stage #(
  parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
  parameter logic [7:0] INT_VEC_ADDR   = 8'h01,
  parameter logic [7:0] INT_INSTR      = 8'hB0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pc_write_en,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  input  logic       int_req,
  input  logic [7:0] imem_data,
  output logic [7:0] imem_addr,
  output logic [7:0] pc_current,
  output logic [7:0] pc_plus1,
  output logic [7:0] instr_out,
  output logic       instr_valid,
  output logic       inject_int,
  output logic [7:0] int_ret_pc,
  output logic       int_ack
);

  typedef enum logic [1:0] {S_RVEC, S_RUN, S_INJ, S_IVEC} state_t;

  state_t     state, state_nxt;
  logic [7:0] pc, pc_nxt;
  logic [7:0] ret_pc, ret_pc_nxt;
  logic       int_req_d;
  logic       int_pending, pending_nxt;
  logic       int_edge;

  assign int_edge   = int_req & ~int_req_d;
  assign pc_current = pc;
  assign pc_plus1   = pc + 8'd1;
  assign int_ret_pc = ret_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RVEC;
      pc          <= 8'h00;
      ret_pc      <= 8'h00;
      int_pending <= 1'b0;
      int_req_d   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ret_pc      <= ret_pc_nxt;
      int_pending <= pending_nxt;
      int_req_d   <= int_req;
    end
  end

  // instr_valid has no ready partner: downstream consumes instr_out in every cycle
  // it is high, and pc_write_en=0 freezes the offered instruction until taken.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ret_pc_nxt  = ret_pc;
    pending_nxt = int_pending;
    imem_addr   = pc;
    instr_out   = 8'h00;
    instr_valid = 1'b0;
    inject_int  = 1'b0;
    int_ack     = 1'b0;
    case (state)
      S_RVEC: begin
        imem_addr = RESET_VEC_ADDR;
        pc_nxt    = imem_data;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        instr_out   = imem_data;
        instr_valid = 1'b1;
        if (pc_write_en) begin
          // A branch wins over a pending interrupt, so the return PC is the target.
          if (branch_taken) begin
            pc_nxt = branch_target;
          end else if (int_pending) begin
            ret_pc_nxt = pc;
            state_nxt  = S_INJ;
          end else begin
            pc_nxt = pc_plus1;
          end
        end
      end
      S_INJ: begin
        instr_out   = INT_INSTR;
        instr_valid = 1'b1;
        inject_int  = 1'b1;
        if (pc_write_en) state_nxt = S_IVEC;
      end
      S_IVEC: begin
        imem_addr   = INT_VEC_ADDR;
        int_ack     = 1'b1;
        pc_nxt      = imem_data;
        pending_nxt = 1'b0;
        state_nxt   = S_RUN;
      end
      default: state_nxt = S_RVEC;
    endcase
    // Edges arriving while an interrupt is already in flight are dropped, not queued.
    if (int_edge && !int_pending && state != S_INJ && state != S_IVEC)
      pending_nxt = 1'b1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of the fetch sequence kept here.
module tb_fetch_stage;

  localparam logic [7:0] RVEC  = 8'h00;
  localparam logic [7:0] IVEC  = 8'h01;
  localparam logic [7:0] IINST = 8'hB0;

  localparam int MODE_BOOT   = 0;
  localparam int MODE_FETCH  = 1;
  localparam int MODE_INJECT = 2;
  localparam int MODE_VECTOR = 3;

  logic       clk, rst;
  logic       pc_write_en, branch_taken, int_req;
  logic [7:0] branch_target, imem_data, imem_addr, pc_current, pc_plus1;
  logic [7:0] instr_out, int_ret_pc;
  logic       instr_valid, inject_int, int_ack;

  logic [7:0] mem [256];
  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_write_en(pc_write_en), .branch_taken(branch_taken),
    .branch_target(branch_target), .int_req(int_req), .imem_data(imem_data),
    .imem_addr(imem_addr), .pc_current(pc_current), .pc_plus1(pc_plus1),
    .instr_out(instr_out), .instr_valid(instr_valid), .inject_int(inject_int),
    .int_ret_pc(int_ret_pc), .int_ack(int_ack)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int ack_cnt = 0;
  string cur_tag = "init";

  // behavioural model
  int         m_mode;
  logic [7:0] m_pc, m_ret;
  logic       m_pend, m_prev_irq;
  logic [7:0] exp_q[$];

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%02h exp=%02h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MODE_BOOT;
    m_pc = 8'h00;
    m_ret = 8'h00;
    m_pend = 1'b0;
    m_prev_irq = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic pwe, input logic br, input logic [7:0] tgt,
                            input logic irq);
    logic rise, pend_was;
    int   mode_was;
    rise = irq && !m_prev_irq;
    pend_was = m_pend;
    mode_was = m_mode;
    m_prev_irq = irq;
    case (m_mode)
      MODE_BOOT: begin
        m_pc = mem[RVEC];
        m_mode = MODE_FETCH;
      end
      MODE_FETCH: if (pwe) begin
        if (br) m_pc = tgt;
        else if (pend_was) begin
          m_ret = m_pc;
          exp_q.push_back(m_pc);
          m_mode = MODE_INJECT;
        end else m_pc = m_pc + 8'd1;
      end
      MODE_INJECT: if (pwe) m_mode = MODE_VECTOR;
      default: begin
        m_pc = mem[IVEC];
        m_pend = 1'b0;
        m_mode = MODE_FETCH;
      end
    endcase
    if (rise && !pend_was && mode_was != MODE_INJECT && mode_was != MODE_VECTOR)
      m_pend = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] e_addr, e_out;
    logic       e_val, e_inj, e_ack;
    e_addr = m_pc; e_out = 8'h00; e_val = 1'b0; e_inj = 1'b0; e_ack = 1'b0;
    case (m_mode)
      MODE_BOOT:   e_addr = RVEC;
      MODE_FETCH:  begin e_out = mem[m_pc]; e_val = 1'b1; end
      MODE_INJECT: begin e_out = IINST; e_val = 1'b1; e_inj = 1'b1; end
      default:     begin e_addr = IVEC; e_ack = 1'b1; end
    endcase
    check8({tag, "/imem_addr"}, imem_addr, e_addr);
    check8({tag, "/pc_current"}, pc_current, m_pc);
    check8({tag, "/pc_plus1"}, pc_plus1, m_pc + 8'd1);
    check8({tag, "/instr_out"}, instr_out, e_out);
    check8({tag, "/instr_valid"}, 8'(instr_valid), 8'(e_val));
    check8({tag, "/inject_int"}, 8'(inject_int), 8'(e_inj));
    check8({tag, "/int_ack"}, 8'(int_ack), 8'(e_ack));
    check8({tag, "/int_ret_pc"}, int_ret_pc, m_ret);
  endtask

  // driver: one clock cycle of stimulus, sampled before the edge, model advanced after
  task automatic cycle(input logic pwe, input logic br, input logic [7:0] tgt,
                       input logic irq);
    @(negedge clk);
    pc_write_en = pwe; branch_taken = br; branch_target = tgt; int_req = irq;
    #1;
    check_outputs(cur_tag);
    if (int_ack) begin
      ack_cnt++;
      check8({cur_tag, "/ack_expected"}, 8'(exp_q.size() > 0), 8'd1);
      if (exp_q.size() > 0) check8({cur_tag, "/ret_sb"}, int_ret_pc, exp_q.pop_front());
    end
    @(posedge clk);
    model_step(pwe, br, tgt, irq);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pc_write_en = 1'b0; branch_taken = 1'b0; int_req = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 check_outputs({cur_tag, "/async_rst"});
    @(posedge clk);
    #1 check_outputs({cur_tag, "/rst_hold"});
    #2 rst = 1'b0;
  endtask

  initial begin
    logic irq;
    rst = 1'b1; pc_write_en = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    int_req = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h10;
    mem[1] = 8'h80;
    model_reset();
    #1 check_outputs("por");
    @(posedge clk);
    #2 rst = 1'b0;

    // boot: one invalid cycle, then the reset vector
    cur_tag = "boot";
    cycle(0, 0, 8'h00, 0);
    #1 check8("boot_pc", pc_current, 8'h10);
    check8("boot_addr", imem_addr, 8'h10);

    // wrap and stall at 8'hFF
    cur_tag = "wrap";
    cycle(1, 1, 8'hFF, 0);
    cycle(0, 0, 8'h00, 0);
    #1 check8("stall_pc", pc_current, 8'hFF);
    check8("stall_instr", instr_out, mem[255]);
    cycle(1, 0, 8'h00, 0);
    #1 check8("wrap_pc", pc_current, 8'h00);

    // branch
    cur_tag = "branch";
    cycle(1, 1, 8'h20, 0);
    cycle(1, 1, 8'h40, 0);
    #1 check8("branch_pc", pc_current, 8'h40);

    // interrupt entered at PC 8'h30
    cur_tag = "irq30";
    cycle(1, 1, 8'h2F, 0);
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    #1 check8("inj_instr", instr_out, 8'hB0);
    check8("inj_flag", 8'(inject_int), 8'd1);
    check8("inj_ret", int_ret_pc, 8'h30);
    cycle(1, 1, 8'h99, 1);
    #1 check8("ivec_ack", 8'(int_ack), 8'd1);
    cycle(1, 0, 8'h00, 1);
    #1 check8("vec_pc", pc_current, 8'h80);

    // pending interrupt meets a branch; second edge during injection is dropped
    cur_tag = "irq_branch";
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 1);
    cycle(1, 1, 8'h50, 1);
    cycle(1, 0, 8'h00, 1);
    #1 check8("br_ret", int_ret_pc, 8'h50);
    ack_cnt = 0;
    cycle(0, 1, 8'h77, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 8'h00, 1);
    check8("single_ack", 8'(ack_cnt), 8'd1);

    // reset while the vector is being loaded
    cur_tag = "rst_ivec";
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    do_reset();
    check8("rst_pc", pc_current, 8'h00);
    check8("rst_ack", 8'(int_ack), 8'd0);
    cycle(0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'h00, 0);

    // random traffic
    cur_tag = "rand";
    irq = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) irq = ~irq;
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
        irq = 1'b0;
      end
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
            8'($urandom_range(0, 255)), irq);
    end
    for (int i = 0; i < 8; i++) cycle(1, 0, 8'h00, irq);
    check8("sb_drained", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
